// File: rtl/fifo_flops_param.sv
// Parametrised flop-based synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and FWFT/registered read.
module fifo_flops_param #(
  parameter int unsigned depth  = 16,
  parameter int unsigned bits   = 32,
  parameter int unsigned af_thr = depth - 2,
  parameter int unsigned ae_thr = 2,
  parameter bit          fwft   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [bits-1:0]              Din,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
  output logic [bits-1:0]              Dout,
  output logic                         full,
  output logic                         pndng,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth + 1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_pndng;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;
  logic [bits-1:0]   r_mem [depth];

  logic              w_pop_acc;
  logic              w_push_acc;
  logic              w_push_only;
  logic              w_pop_only;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [CW-1:0]     w_count_nxt;

  // Pointers wrap by explicit compare so non-power-of-2 depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Accept decisions; a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    w_pop_acc   = pop && (r_state != S_EMPTY);
    w_push_acc  = push && ((r_state != S_FULL) || w_pop_acc);
    w_push_only = w_push_acc && !w_pop_acc;
    w_pop_only  = w_pop_acc && !w_push_acc;
    w_ovf_set   = push && !w_push_acc;
    w_unf_set   = pop && !w_pop_acc;
    w_count_nxt = r_count;
    if (w_push_only) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop_only) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Status FSM plus registered occupancy flags, all derived from the next count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_EMPTY;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_pndng        <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push_only) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_push_only && (r_count == CW'(depth - 1))) begin
            r_state <= S_FULL;
          end else if (w_pop_only && (r_count == CW'(1))) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop_only) r_state <= S_ACTIVE;
        end
        default: r_state <= S_EMPTY;
      endcase
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == CW'(depth));
      r_pndng        <= (w_count_nxt != '0);
      r_almost_full  <= (w_count_nxt >= CW'(af_thr));
      r_almost_empty <= (w_count_nxt <= CW'(ae_thr));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_acc)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '{default: '0};
    end else if (w_push_acc) begin
      r_mem[r_wr_ptr] <= Din;
    end
  end

  // Sticky errors: a new error in the clearing cycle wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set || (r_overflow && !clr_err);
      r_underflow <= w_unf_set || (r_underflow && !clr_err);
    end
  end

  generate
    if (fwft) begin : g_fwft
      assign Dout = r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [bits-1:0] r_dout;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dout <= '0;
        end else if (w_pop_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign Dout = r_dout;
    end
  endgenerate

  assign full         = r_full;
  assign pndng        = r_pndng;
  assign count        = r_count;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flops_param.sv
// Bench for fifo_flops_param: directed and random traffic on three configurations,
// compared against a queue-based reference model.
module tb_fifo_flops_param;

  logic clk;
  logic rst;

  logic [31:0] din0, din1, din2;
  logic        push0, push1, push2;
  logic        pop0, pop1, pop2;
  logic        clr0, clr1, clr2;

  logic [31:0] dout0, dout1, dout2;
  logic        full0, full1, full2;
  logic        pndng0, pndng1, pndng2;
  logic [4:0]  cnt0;
  logic [2:0]  cnt1, cnt2;
  logic        af0, af1, af2;
  logic        ae0, ae1, ae2;
  logic        ovf0, ovf1, ovf2;
  logic        unf0, unf1, unf2;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] mq[$];
  int          m_depth, m_af, m_ae;
  bit          m_fwft;
  logic        m_ovf, m_unf;
  logic [31:0] m_dq;

  fifo_flops_param #(.depth(16), .bits(32)) u0 (
    .clk(clk), .rst(rst), .Din(din0), .push(push0), .pop(pop0), .clr_err(clr0),
    .Dout(dout0), .full(full0), .pndng(pndng0), .count(cnt0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_flops_param #(.depth(5), .bits(32), .af_thr(4), .ae_thr(1), .fwft(1'b1)) u1 (
    .clk(clk), .rst(rst), .Din(din1), .push(push1), .pop(pop1), .clr_err(clr1),
    .Dout(dout1), .full(full1), .pndng(pndng1), .count(cnt1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
  );

  fifo_flops_param #(.depth(5), .bits(32), .af_thr(4), .ae_thr(1), .fwft(1'b0)) u2 (
    .clk(clk), .rst(rst), .Din(din2), .push(push2), .pop(pop2), .clr_err(clr2),
    .Dout(dout2), .full(full2), .pndng(pndng2), .count(cnt2),
    .almost_full(af2), .almost_empty(ae2), .overflow(ovf2), .underflow(unf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_dq  = '0;
    if (d == 0) begin
      m_depth = 16; m_af = 14; m_ae = 2; m_fwft = 1'b1;
    end else begin
      m_depth = 5;  m_af = 4;  m_ae = 1; m_fwft = (d == 1);
    end
  endtask

  task automatic sample(input int d, output logic [31:0] o_dout, output int o_cnt,
                        output logic o_full, output logic o_pndng, output logic o_af,
                        output logic o_ae, output logic o_ovf, output logic o_unf);
    case (d)
      0: begin o_dout = dout0; o_cnt = int'(cnt0); o_full = full0; o_pndng = pndng0;
               o_af = af0; o_ae = ae0; o_ovf = ovf0; o_unf = unf0; end
      1: begin o_dout = dout1; o_cnt = int'(cnt1); o_full = full1; o_pndng = pndng1;
               o_af = af1; o_ae = ae1; o_ovf = ovf1; o_unf = unf1; end
      default: begin o_dout = dout2; o_cnt = int'(cnt2); o_full = full2; o_pndng = pndng2;
               o_af = af2; o_ae = ae2; o_ovf = ovf2; o_unf = unf2; end
    endcase
  endtask

  task automatic check_all(input int d);
    logic [31:0] o_dout;
    int          o_cnt;
    logic        o_full, o_pndng, o_af, o_ae, o_ovf, o_unf;
    int          sz;
    sample(d, o_dout, o_cnt, o_full, o_pndng, o_af, o_ae, o_ovf, o_unf);
    sz = mq.size();
    chk("count",        32'(o_cnt),   32'(sz));
    chk("full",         32'(o_full),  32'(sz == m_depth));
    chk("pndng",        32'(o_pndng), 32'(sz != 0));
    chk("almost_full",  32'(o_af),    32'(sz >= m_af));
    chk("almost_empty", 32'(o_ae),    32'(sz <= m_ae));
    chk("overflow",     32'(o_ovf),   32'(m_ovf));
    chk("underflow",    32'(o_unf),   32'(m_unf));
    if (m_fwft) begin
      if (sz != 0) chk("dout_fwft", o_dout, mq[0]);
    end else begin
      chk("dout_reg", o_dout, m_dq);
    end
  endtask

  task automatic drive_idle();
    din0 = '0; din1 = '0; din2 = '0;
    push0 = 1'b0; push1 = 1'b0; push2 = 1'b0;
    pop0 = 1'b0; pop1 = 1'b0; pop2 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
  endtask

  // One clock cycle of traffic on instance d, then model update and full check
  task automatic step(input int d, input logic pu, input logic po, input logic cl,
                      input logic [31:0] din);
    logic        pop_ok, push_ok;
    logic [31:0] popped;
    drive_idle();
    case (d)
      0: begin din0 = din; push0 = pu; pop0 = po; clr0 = cl; end
      1: begin din1 = din; push1 = pu; pop1 = po; clr1 = cl; end
      default: begin din2 = din; push2 = pu; pop2 = po; clr2 = cl; end
    endcase
    @(posedge clk);
    pop_ok  = po && (mq.size() != 0);
    push_ok = pu && ((mq.size() < m_depth) || pop_ok);
    if (pop_ok) begin
      popped = mq.pop_front();
      if (!m_fwft) m_dq = popped;
    end
    if (push_ok) mq.push_back(din);
    m_ovf = (pu && !push_ok) ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_unf = (po && !pop_ok)  ? 1'b1 : (cl ? 1'b0 : m_unf);
    @(negedge clk);
    check_all(d);
  endtask

  task automatic random_run(input int d);
    int pu_pct, po_pct;
    for (int c = 0; c < 40; c++) begin
      pu_pct = (c < 20) ? 70 : 40;
      po_pct = (c < 20) ? 40 : 70;
      step(d, $urandom_range(0, 99) < pu_pct, $urandom_range(0, 99) < po_pct,
           $urandom_range(0, 99) < 10, $urandom);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive_idle();
    model_reset(0);

    // Reset state
    repeat (2) @(negedge clk);
    check_all(0);
    chk("rst_dout", dout0, 32'h0);
    chk("rst_dout_reg", dout2, 32'h0);
    rst = 1'b1;

    // Fill to full, overflow, then drain in order
    for (int i = 1; i <= 16; i++) step(0, 1'b1, 1'b0, 1'b0, 32'(i));
    step(0, 1'b1, 1'b0, 1'b0, 32'hFF);
    chk("ovf_17th_count", 32'(cnt0), 32'd16);
    chk("ovf_17th_flag", 32'(ovf0), 32'd1);
    step(0, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", dout0, 32'(i));
      step(0, 1'b0, 1'b1, 1'b0, 32'h0);
    end

    // Underflow on empty, then clear
    step(0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("unf_set", 32'(unf0), 32'd1);
    step(0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("unf_clr", 32'(unf0), 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b0, $urandom);
    step(0, 1'b1, 1'b1, 1'b0, 32'hAA);
    chk("full_pp_count", 32'(cnt0), 32'd16);
    chk("full_pp_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("aa_16th_read", dout0, 32'hAA);
      step(0, 1'b0, 1'b1, 1'b0, 32'h0);
    end

    // Asynchronous reset mid-burst with count=7
    for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
    chk("pre_rst_count", 32'(cnt0), 32'd7);
    drive_idle();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(cnt0), 32'd0);
    chk("async_rst_full", 32'(full0), 32'd0);
    chk("async_rst_pndng", 32'(pndng0), 32'd0);
    chk("async_rst_af", 32'(af0), 32'd0);
    chk("async_rst_ae", 32'(ae0), 32'd1);
    chk("async_rst_ovf", 32'(ovf0), 32'd0);
    chk("async_rst_unf", 32'(unf0), 32'd0);
    chk("async_rst_dout", dout0, 32'h0);
    model_reset(0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 1'b1, 1'b0, 1'b0, 32'h5A);
    chk("post_rst_5a", dout0, 32'h5A);
    step(0, 1'b0, 1'b1, 1'b0, 32'h0);

    // depth=5 random traffic, FWFT then registered read
    model_reset(1);
    random_run(1);
    model_reset(2);
    random_run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
